// File: rtl/reg_writeback_arbiter_if.sv
// rtl/reg_writeback_arbiter_if.sv - producer/register-file bundle for the write-back arbiter
interface reg_writeback_arbiter_if;
  // ALU result producer (valid/ready handshake)
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  // load result producer (no back-pressure)
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  // register file write port
  logic        regWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  // pending-write bitmap for decode stall logic
  logic [31:0] busy;

  // pipeline side: drives producer results, observes the write port
  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    input  alu_ready,
    input  regWrite, write_reg, write_data,
    input  busy
  );

  // arbiter side
  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    output alu_ready,
    output regWrite, write_reg, write_data,
    output busy
  );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// rtl/reg_writeback_arbiter.sv - register file write-port owner merging load and ALU results
module reg_writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  reg_writeback_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // ALU result FIFO storage and bookkeeping
  logic [4:0]       fifo_reg  [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  // registered write port
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  // per-cycle decisions
  logic alu_ready_c;
  logic alu_fire;
  logic alu_live;
  logic mem_live;
  logic fifo_empty;
  logic sel_mem;
  logic sel_pop;
  logic sel_byp;
  logic push;
  logic pop;
  logic [31:0] busy_c;

  // Ready depends on occupancy only, so a same-cycle pop never opens a slot early.
  always_comb begin
    alu_ready_c = (count != FULL_COUNT);
    fifo_empty  = (count == '0);
    alu_fire    = bus.alu_valid && alu_ready_c;
    // reg 0 results complete the handshake but are dropped on the floor
    alu_live    = alu_fire && (bus.alu_reg != 5'd0);
    mem_live    = bus.mem_valid && (bus.mem_reg != 5'd0);
  end

  // Priority: load, then FIFO head, then direct ALU bypass when nothing is queued.
  always_comb begin
    sel_mem = mem_live;
    sel_pop = !mem_live && !fifo_empty;
    sel_byp = !mem_live && fifo_empty && alu_live;
    pop     = sel_pop;
    // an ALU result that cannot go straight out waits its turn behind older entries
    push    = alu_live && !sel_byp;
  end

  // Output stage: one write per cycle, address/data hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_en   <= 1'b0;
      wb_reg  <= 5'd0;
      wb_data <= 32'd0;
    end else if (sel_mem) begin
      wb_en   <= 1'b1;
      wb_reg  <= bus.mem_reg;
      wb_data <= bus.mem_data;
    end else if (sel_pop) begin
      wb_en   <= 1'b1;
      wb_reg  <= fifo_reg[rd_ptr];
      wb_data <= fifo_data[rd_ptr];
    end else if (sel_byp) begin
      wb_en   <= 1'b1;
      wb_reg  <= bus.alu_reg;
      wb_data <= bus.alu_data;
    end else begin
      wb_en   <= 1'b0;
    end
  end

  // FIFO payload; contents need no reset because slot_valid and count gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= bus.alu_reg;
      fifo_data[wr_ptr] <= bus.alu_data;
    end
  end

  // FIFO pointers, occupancy and per-slot valid bits used by the busy map.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else begin
      if (pop) begin
        rd_ptr             <= rd_ptr + PW'(1);
        slot_valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr             <= wr_ptr + PW'(1);
        slot_valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Pending-write bitmap: queued entries plus the write currently on the port.
  always_comb begin
    busy_c = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        busy_c[fifo_reg[i]] = 1'b1;
      end
    end
    if (wb_en) begin
      busy_c[wb_reg] = 1'b1;
    end
    busy_c[0] = 1'b0;
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.alu_ready  = alu_ready_c;
    bus.regWrite   = wb_en;
    bus.write_reg  = wb_reg;
    bus.write_data = wb_data;
    bus.busy       = busy_c;
  end

endmodule
